store_align_unit: RTL and testbench

Data-memory store stage directly downstream of the store-size decoder. Takes one decoded store per handshake (size code 00 byte, 01 half, 10 word, 11 none), checks alignment, and replicates the data onto the correct byte lanes. Generates byte strobes and drives a single-outstanding req/ack write transaction to data memory. Reports completion, misalignment or bus timeout back to the pipeline.

---
 rtl/store_align_unit.sv | 134 +++++++++++++
 tb/tb_store_align_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/store_align_unit.sv
// Data-memory store stage: checks store alignment, replicates data onto byte lanes
// and runs one outstanding req/ack write, reporting done, misaligned or timeout.
module store_align_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_type,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  output logic              st_done,
  output logic              st_fault,
  output logic [1:0]        fault_code,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] T_BYTE = 2'b00;
  localparam logic [1:0] T_HALF = 2'b01;
  localparam logic [1:0] T_WORD = 2'b10;
  localparam logic [1:0] T_NONE = 2'b11;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_ALIGN = 2'b01;
  localparam logic [1:0] FC_TMO   = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  function automatic logic [31:0] lane_data(input logic [1:0] typ, input logic [31:0] d);
    logic [31:0] r;
    case (typ)
      T_BYTE:  r = {4{d[7:0]}};
      T_HALF:  r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_strb(input logic [1:0] typ, input logic [1:0] a);
    logic [3:0] r;
    case (typ)
      T_BYTE:  r = 4'b0001 << a;
      T_HALF:  r = a[1] ? 4'b1100 : 4'b0011;
      T_WORD:  r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [1:0] typ, input logic [1:0] a);
    return ((typ == T_HALF) && a[0]) || ((typ == T_WORD) && (a != 2'b00));
  endfunction

  logic accept;

  assign st_ready = (state == IDLE) && !rst;
  assign accept   = st_valid && st_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      st_done    <= 1'b0;
      st_fault   <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (st_type == T_NONE) begin
              state   <= DONE;
              st_done <= 1'b1;
            end else if (misaligned(st_type, st_addr[1:0])) begin
              state      <= FAULT;
              st_fault   <= 1'b1;
              fault_code <= FC_ALIGN;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= lane_data(st_type, st_data);
              mem_wstrb <= lane_strb(st_type, st_addr[1:0]);
              cnt       <= '0;
            end
          end
        end
        REQ: begin
          // an ack arriving in the last allowed cycle still completes the store
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            st_done <= 1'b1;
          end else if (cnt == CNT_LIM) begin
            state      <= FAULT;
            mem_req    <= 1'b0;
            st_fault   <= 1'b1;
            fault_code <= FC_TMO;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          st_done <= 1'b0;
        end
        FAULT: begin
          state      <= IDLE;
          st_fault   <= 1'b0;
          fault_code <= FC_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit with TIMEOUT=4: lane/strobe rules,
// alignment faults, no-op, bus timeout, ack-at-limit and reset mid-transaction.
module tb_store_align_unit;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              st_valid;
  logic              st_ready;
  logic [1:0]        st_type;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ack;
  logic              st_done;
  logic              st_fault;
  logic [1:0]        fault_code;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  store_align_unit #(.ADDR_W(ADDR_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_type(st_type),
    .st_addr(st_addr), .st_data(st_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .st_done(st_done), .st_fault(st_fault), .fault_code(fault_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // presents one request for a single cycle; returns in the first cycle after accept
  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
    tick();
    st_valid = 1'b0;
  endtask

  // ack_at: which mem_req cycle gets mem_ack (0 = never)
  task automatic run_case(input string tag, input logic [1:0] t, input logic [31:0] a,
                          input logic [31:0] d, input int ack_at, input bit hold_valid,
                          input int exp_reqc, input int exp_rep, input bit exp_done,
                          input logic [1:0] exp_code, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    int          reqc = 0;
    int          rep  = -1;
    bit          stable = 1'b1;
    logic        got_done = 1'b0;
    logic        got_fault = 1'b0;
    logic [1:0]  got_code = 2'b00;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    issue(t, a, d);
    if (hold_valid) begin
      // new request fields while busy must be ignored
      st_valid = 1'b1;
      st_type  = 2'b10;
      st_addr  = 32'h0000_0040;
      st_data  = 32'hFFFF_FFFF;
    end
    for (int c = 1; c <= 30; c++) begin
      if (mem_req) begin
        reqc++;
        if (reqc == 1) begin
          cap_addr  = mem_addr;
          cap_wdata = mem_wdata;
          cap_wstrb = mem_wstrb;
        end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_wstrb !== cap_wstrb) begin
          stable = 1'b0;
        end
      end
      mem_ack = mem_req && (reqc == ack_at);
      if (st_done || st_fault) begin
        rep       = c;
        got_done  = st_done;
        got_fault = st_fault;
        got_code  = fault_code;
        break;
      end
      tick();
    end
    mem_ack  = 1'b0;
    st_valid = 1'b0;
    check_eq({tag, ".req_cycles"}, reqc, exp_reqc);
    check_eq({tag, ".report_cycle"}, rep, exp_rep);
    check_eq({tag, ".done"}, {31'b0, got_done}, {31'b0, exp_done});
    check_eq({tag, ".fault"}, {31'b0, got_fault}, {31'b0, !exp_done});
    check_eq({tag, ".code"}, {30'b0, got_code}, {30'b0, exp_code});
    if (exp_reqc > 0) begin
      check_eq({tag, ".addr"}, cap_addr, exp_addr);
      check_eq({tag, ".wdata"}, cap_wdata, exp_wdata);
      check_eq({tag, ".wstrb"}, {28'b0, cap_wstrb}, {28'b0, exp_wstrb});
      check_eq({tag, ".stable"}, {31'b0, stable}, 32'd1);
    end
    tick();
    check_eq({tag, ".ready_after"}, {31'b0, st_ready}, 32'd1);
    check_eq({tag, ".pulse_clear"}, {30'b0, st_done, st_fault}, 32'd0);
    check_eq({tag, ".code_clear"}, {30'b0, fault_code}, 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    st_valid = 1'b0;
    st_type  = 2'b11;
    st_addr  = '0;
    st_data  = '0;
    mem_ack  = 1'b0;
    tick();
    tick();
    check_eq("rst.ready", {31'b0, st_ready}, 32'd0);
    check_eq("rst.req", {31'b0, mem_req}, 32'd0);
    check_eq("rst.busy", {31'b0, busy}, 32'd0);
    check_eq("rst.pulses", {30'b0, st_done, st_fault}, 32'd0);
    check_eq("rst.code", {30'b0, fault_code}, 32'd0);
    check_eq("rst.addr", mem_addr, 32'd0);
    check_eq("rst.wdata", mem_wdata, 32'd0);
    check_eq("rst.wstrb", {28'b0, mem_wstrb}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("idle.ready", {31'b0, st_ready}, 32'd1);

    // stray ack while idle does nothing
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_eq("stray_ack.pulses", {30'b0, st_done, st_fault}, 32'd0);
    check_eq("stray_ack.busy", {31'b0, busy}, 32'd0);

    run_case("byte", 2'b00, 32'h0000_1003, 32'h0000_00AB, 3, 1'b0,
             3, 4, 1'b1, 2'b00, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
    run_case("byte0", 2'b00, 32'h0000_1001, 32'h1234_56CD, 1, 1'b0,
             1, 2, 1'b1, 2'b00, 32'h0000_1000, 32'hCDCD_CDCD, 4'b0010);
    run_case("half_lo", 2'b01, 32'h0000_0010, 32'h0000_1234, 1, 1'b0,
             1, 2, 1'b1, 2'b00, 32'h0000_0010, 32'h1234_1234, 4'b0011);
    run_case("half_hi", 2'b01, 32'h0000_0012, 32'h0000_5678, 1, 1'b0,
             1, 2, 1'b1, 2'b00, 32'h0000_0010, 32'h5678_5678, 4'b1100);
    run_case("word", 2'b10, 32'h0000_0020, 32'hDEAD_BEEF, 1, 1'b0,
             1, 2, 1'b1, 2'b00, 32'h0000_0020, 32'hDEAD_BEEF, 4'b1111);
    run_case("mis_half", 2'b01, 32'h0000_2001, 32'h0000_1111, 1, 1'b0,
             0, 1, 1'b0, 2'b01, 32'h0, 32'h0, 4'b0);
    run_case("mis_word", 2'b10, 32'h0000_2002, 32'h2222_2222, 1, 1'b0,
             0, 1, 1'b0, 2'b01, 32'h0, 32'h0, 4'b0);
    run_case("noop", 2'b11, 32'h0000_3007, 32'h3333_3333, 1, 1'b0,
             0, 1, 1'b1, 2'b00, 32'h0, 32'h0, 4'b0);
    run_case("timeout", 2'b10, 32'h0000_0024, 32'hCAFE_F00D, 0, 1'b1,
             4, 5, 1'b0, 2'b10, 32'h0000_0024, 32'hCAFE_F00D, 4'b1111);
    run_case("ack_at_limit", 2'b10, 32'h0000_0028, 32'h0BAD_CAFE, 4, 1'b1,
             4, 5, 1'b1, 2'b00, 32'h0000_0028, 32'h0BAD_CAFE, 4'b1111);

    // reset two cycles into REQ abandons the store silently
    issue(2'b10, 32'h0000_0030, 32'h5555_AAAA);
    check_eq("rstmid.req_on", {31'b0, mem_req}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check_eq("rstmid.req_off", {31'b0, mem_req}, 32'd0);
    check_eq("rstmid.busy", {31'b0, busy}, 32'd0);
    check_eq("rstmid.pulses", {30'b0, st_done, st_fault}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rstmid.ready", {31'b0, st_ready}, 32'd1);
    tick();
    check_eq("rstmid.quiet", {29'b0, st_done, st_fault, mem_req}, 32'd0);
    run_case("post_rst_word", 2'b10, 32'h0000_0034, 32'h0102_0304, 2, 1'b0,
             2, 3, 1'b1, 2'b00, 32'h0000_0034, 32'h0102_0304, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
